sevenseg_fmt: RTL and testbench
===============================

Name: sevenseg_fmt

Overview:
Sequential number-to-display formatter that feeds the eight 7-bit digit codes of the extended seven-segment controller.
- Converts a captured 16-bit value, signed or unsigned, to decimal using iterative double-dabble, one bit per clock.
- Alternatively passes the value through as 4 hex digits.
- Applies leading-zero blanking and places a minus sign.
- Holds its registered digit outputs stable between conversions, so the display never shows partial results.

Parameters:
LZ_BLANK, 1, 1 = blank leading zeros in decimal mode; 0 = always show d4..d0 in decimal mode.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
start  input  1  request conversion; accepted only in IDLE
value  input  16  number to display; sampled on the accepting edge
is_signed  input  1  1 = value is two's complement; sampled with start
hex_mode  input  1  1 = hex display, no conversion; sampled with start
busy  output  1  high in SHIFT and FMT states
done  output  1  one-cycle pulse when new digits become valid
d7..d0  output  7 each  digit codes: [6] blank, [5] dp, [4] dash, [3:0] hex nibble

Behaviour:
- Reset (synchronous, active high, clk edge):
  - state = IDLE, busy = 0, done = 0.
  - All d7..d0 = BLANK (7'b100_0000).
  - Reset during SHIFT/FMT aborts the conversion with no done pulse.
- dp bit (bit 5) is always 0 in every output code.
- States:
  - IDLE: on edge with start=1:
    - Capture raw value and the mode bits.
    - neg = is_signed & value[15] & ~hex_mode.
    - mag = neg ? -value : value, as 16-bit unsigned; 0x8000 yields 32768.
    - Clear 20-bit BCD (5 digits) and 4-bit counter; go to SHIFT.
  - SHIFT:
    - Each edge: every BCD digit >= 5 gets +3, then {bcd, mag} shifts left by 1 and the counter increments.
    - After the 16th shift, go to FMT.
    - In hex_mode the shifts still run (result unused), so latency is mode-independent.
  - FMT: one edge that does all of the following:
    - Write d7..d0 and pulse done = 1 for the next cycle.
    - Return to IDLE.
- Latency:
  - Start accepted at edge 0; shifts occur at edges 1..16; outputs update at edge 17.
  - done is high in the cycle after edge 17, and busy is high after edges 0..16 (17 cycles).
  - start may be accepted again on the edge that samples done = 1.
- Decimal formatting:
  - BCD digits b4..b0 map to d4..d0.
  - k = index of the most significant nonzero digit; k = 0 if mag = 0, so "0" is always shown in d0.
  - LZ_BLANK=1: positions above k are BLANK.
  - If neg: DASH (7'b001_0000) goes in position k+1 (LZ_BLANK=1), or in d5 (LZ_BLANK=0).
  - d7 and d6 are always BLANK; d5 is BLANK unless it holds the dash.
- Hex formatting:
  - d3..d0 = nibbles of the raw captured value, with no blanking.
  - d7..d4 = BLANK; no dash.
- Boundary conditions:
  - start while busy is ignored; captured operands do not change.
  - start held high re-triggers every 18 cycles.
  - Input changes after capture have no effect.
  - The 16-bit magnitude never exceeds 65535, so 5 BCD digits never overflow.

Decomposition:
- Shared package sevenseg_pkg:
  - Digit code typedef (7-bit packed struct: blank, dp, dash, nib).
  - Constants BLANK, DASH, DIG(n).
  - State enum {IDLE, SHIFT, FMT}.
- One combinational sub-module, dd_adjust: 20-bit BCD in, per-digit add-3 corrected BCD out, instantiated once.

Test Plan:
- Unsigned 1234, LZ_BLANK=1 -> d3..d0 = 1,2,3,4; d7..d4 = 7'h40; done exactly 18 cycles after the start cycle; busy high 17 cycles.
- Signed 0xFFFF -> d1 = DASH (7'h10), d0 = 7'h01, rest BLANK. Unsigned 0xFFFF -> 6,5,5,3,5 on d4..d0.
- Signed 0x8000 -> d5 = DASH, d4..d0 = 3,2,7,6,8. Value 0 -> d0 = 7'h00, all others BLANK.
- hex_mode=1, value 0xBEEF, is_signed=1 -> d3..d0 = 0x0B,0x0E,0x0E,0x0F; no dash; same 17-cycle latency.
- LZ_BLANK=0, signed -42 -> d5 = DASH, d4..d0 = 0,0,0,4,2.
- start pulsed at cycles 5 and 10 with different values -> only the first converts. Separately, rst at cycle 8 mid-SHIFT -> all digits = 7'h40 and no done pulse. Outputs hold previous digits unchanged throughout any conversion.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment number formatter.
package sevenseg_pkg;

  // Digit code driven to the display controller, MSB first: blank, dp, dash, nibble
  typedef struct packed {
    logic       blank;
    logic       dp;
    logic       dash;
    logic [3:0] nib;
  } digit_t;

  localparam digit_t BLANK = '{blank: 1'b1, dp: 1'b0, dash: 1'b0, nib: 4'h0};
  localparam digit_t DASH  = '{blank: 1'b0, dp: 1'b0, dash: 1'b1, nib: 4'h0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FMT   = 2'd2
  } state_t;

  // Plain visible digit showing nibble n
  function automatic digit_t DIG(input logic [3:0] n);
    return '{blank: 1'b0, dp: 1'b0, dash: 1'b0, nib: n};
  endfunction

endpackage

// File: rtl/sevenseg_fmt_dd_adjust.sv
// Double-dabble correction step: every BCD digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module dd_adjust (
  input  logic [19:0] i_bcd,
  output logic [19:0] o_bcd
);

  // Per-digit add-3 correction
  always_comb begin
    o_bcd = i_bcd;
    for (int i = 0; i < 5; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5) o_bcd[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
    end
  end

endmodule

// File: rtl/sevenseg_fmt.sv
// Sequential 16-bit to seven-segment digit formatter. Decimal conversion
// runs one double-dabble bit per clock; hex mode passes nibbles through
// but keeps the same latency. Digit outputs only change on the FMT edge.
//
//   state | meaning
//   IDLE  | waiting for start, digits hold last result
//   SHIFT | 16 double-dabble shifts of {bcd, mag}
//   FMT   | blanking/dash placement, digits and done registered
module sevenseg_fmt
  import sevenseg_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        is_signed,
  input  logic        hex_mode,
  output logic        busy,
  output logic        done,
  output logic [6:0]  d7,
  output logic [6:0]  d6,
  output logic [6:0]  d5,
  output logic [6:0]  d4,
  output logic [6:0]  d3,
  output logic [6:0]  d2,
  output logic [6:0]  d1,
  output logic [6:0]  d0
);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_neg;
  logic             r_hex;
  logic [15:0]      r_raw;
  logic [15:0]      r_mag;
  logic [19:0]      r_bcd;
  logic [3:0]       r_cnt;
  digit_t [7:0]     r_d;

  logic             w_neg;
  logic [15:0]      w_mag;
  logic [19:0]      w_adj;
  digit_t [7:0]     w_fmt;
  int               w_k;

  // Magnitude is taken modulo 2^16 so 0x8000 becomes 32768
  assign w_neg = is_signed & value[15] & ~hex_mode;
  assign w_mag = w_neg ? (~value + 16'd1) : value;

  dd_adjust u_adj (
    .i_bcd (r_bcd),
    .o_bcd (w_adj)
  );

  // Final digit layout from the finished BCD or the raw value
  always_comb begin
    w_k = 0;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_k = i;
    end
    for (int i = 0; i < 8; i++) w_fmt[i] = BLANK;
    if (r_hex) begin
      for (int i = 0; i < 4; i++) w_fmt[i] = DIG(r_raw[4*i +: 4]);
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!LZ_BLANK || i <= w_k) w_fmt[i] = DIG(r_bcd[4*i +: 4]);
      end
      if (r_neg) begin
        for (int i = 0; i < 8; i++) begin
          if (LZ_BLANK ? (i == w_k + 1) : (i == 5)) w_fmt[i] = DASH;
        end
      end
    end
  end

  // Control FSM with registered busy/done/digits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_neg   <= 1'b0;
      r_hex   <= 1'b0;
      r_raw   <= '0;
      r_mag   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < 8; i++) r_d[i] <= BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_raw   <= value;
            r_hex   <= hex_mode;
            r_neg   <= w_neg;
            r_mag   <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= {w_adj[18:0], r_mag[15]};
          r_mag <= {r_mag[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= FMT;
        end
        FMT: begin
          r_d     <= w_fmt;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d7   = r_d[7];
  assign d6   = r_d[6];
  assign d5   = r_d[5];
  assign d4   = r_d[4];
  assign d3   = r_d[3];
  assign d2   = r_d[2];
  assign d1   = r_d[1];
  assign d0   = r_d[0];

endmodule

// File: tb/tb_sevenseg_fmt.sv
// Self-checking bench for sevenseg_fmt: one instance per LZ_BLANK setting,
// both driven by the same stimulus and checked against an arithmetic model.
module tb_sevenseg_fmt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        is_signed = 1'b0;
  logic        hex_mode = 1'b0;

  logic        busy_a, done_a, busy_b, done_b;
  logic [6:0]  a7, a6, a5, a4, a3, a2, a1, a0;
  logic [6:0]  b7, b6, b5, b4, b3, b2, b1, b0;
  logic [55:0] out_a, out_b;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [55:0] ALL_BLANK = {8{7'h40}};

  logic [55:0] prev_a = ALL_BLANK;
  logic [55:0] prev_b = ALL_BLANK;

  always #5 clk = ~clk;

  sevenseg_fmt #(.LZ_BLANK(1'b1)) u_lz1 (
    .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .busy(busy_a), .done(done_a),
    .d7(a7), .d6(a6), .d5(a5), .d4(a4), .d3(a3), .d2(a2), .d1(a1), .d0(a0)
  );

  sevenseg_fmt #(.LZ_BLANK(1'b0)) u_lz0 (
    .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
    .hex_mode(hex_mode), .busy(busy_b), .done(done_b),
    .d7(b7), .d6(b6), .d5(b5), .d4(b4), .d3(b3), .d2(b2), .d1(b1), .d0(b0)
  );

  assign out_a = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign out_b = {b7, b6, b5, b4, b3, b2, b1, b0};

  // Expected digits {d7..d0} computed with decimal arithmetic
  function automatic logic [55:0] model(input logic [15:0] v, input bit s, input bit h, input bit lz);
    logic [55:0] r;
    logic [3:0]  nib;
    int          digs[5];
    int          mag;
    int          k;
    bit          neg;
    r = ALL_BLANK;
    if (h) begin
      for (int i = 0; i < 4; i++) begin
        nib = v[4*i +: 4];
        r[7*i +: 7] = {3'b000, nib};
      end
    end else begin
      neg = s && v[15];
      mag = neg ? (65536 - int'(v)) : int'(v);
      for (int i = 0; i < 5; i++) begin
        digs[i] = mag % 10;
        mag = mag / 10;
      end
      k = 0;
      for (int i = 0; i < 5; i++) if (digs[i] != 0) k = i;
      for (int i = 0; i < 5; i++) begin
        nib = 4'(digs[i]);
        if (!lz || i <= k) r[7*i +: 7] = {3'b000, nib};
      end
      if (neg) begin
        if (lz) r[7*(k+1) +: 7] = 7'h10;
        else    r[7*5 +: 7]     = 7'h10;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one conversion from an IDLE cycle (called at #1 after an edge).
  // inj >= 0 pulses start with a different value that cycle (must be ignored).
  task automatic conv(input string tag, input logic [15:0] v, input bit s, input bit h, input int inj);
    logic [55:0] ea, eb;
    bit          ok;
    ea = model(v, s, h, 1'b1);
    eb = model(v, s, h, 1'b0);
    value = v; is_signed = s; hex_mode = h; start = 1'b1;
    ok = 1'b1;
    for (int n = 0; n < 18; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        start = 1'b0;
        value = 16'($urandom); is_signed = 1'($urandom); hex_mode = 1'($urandom);
      end
      if (n == inj) begin
        start = 1'b1; value = v ^ 16'h5A5A; is_signed = ~s; hex_mode = ~h;
      end
      if (n == inj + 1) start = 1'b0;
      if (n < 17) begin
        if (!(busy_a && busy_b && !done_a && !done_b && out_a == prev_a && out_b == prev_b)) ok = 1'b0;
      end
    end
    chk({tag, " busy/hold"}, {63'd0, ok}, 64'd1);
    chk({tag, " done"}, {62'd0, done_a, done_b}, 64'd3);
    chk({tag, " busy_end"}, {62'd0, busy_a, busy_b}, 64'd0);
    chk({tag, " lz1"}, {8'd0, out_a}, {8'd0, ea});
    chk({tag, " lz0"}, {8'd0, out_b}, {8'd0, eb});
    prev_a = ea;
    prev_b = eb;
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {62'd0, done_a, done_b}, 64'd0);
  endtask

  int          pulses;
  int          first_p;
  int          second_p;
  bit          seen_done;
  logic [15:0] rv;
  bit          rs, rh;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset digits a", {8'd0, out_a}, {8'd0, ALL_BLANK});
    chk("reset digits b", {8'd0, out_b}, {8'd0, ALL_BLANK});
    chk("reset busy/done", {60'd0, busy_a, done_a, busy_b, done_b}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    conv("u1234",     16'd1234,  1'b0, 1'b0, -1);
    conv("s_ffff",    16'hFFFF,  1'b1, 1'b0, -1);
    conv("u_ffff",    16'hFFFF,  1'b0, 1'b0, -1);
    conv("s_8000",    16'h8000,  1'b1, 1'b0, -1);
    conv("zero",      16'd0,     1'b1, 1'b0, -1);
    conv("hex_beef",  16'hBEEF,  1'b1, 1'b1, -1);
    conv("s_m42",     16'hFFD6,  1'b1, 1'b0, -1);
    conv("s_pos",     16'd7,     1'b1, 1'b0, -1);
    conv("ignore",    16'd31415, 1'b0, 1'b0, 5);
    conv("ignore2",   16'hFC19,  1'b1, 1'b0, 10);

    for (int t = 0; t < 16; t++) begin
      rv = 16'($urandom);
      rs = 1'($urandom);
      rh = ($urandom_range(0, 3) == 0);
      conv("rand", rv, rs, rh, -1);
    end

    // Reset mid-SHIFT aborts: digits blank, no done pulse
    value = 16'd999; is_signed = 1'b0; hex_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort digits a", {8'd0, out_a}, {8'd0, ALL_BLANK});
    chk("abort digits b", {8'd0, out_b}, {8'd0, ALL_BLANK});
    seen_done = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (done_a || done_b || busy_a || busy_b) seen_done = 1'b1;
    end
    chk("abort no done", {63'd0, seen_done}, 64'd0);
    prev_a = ALL_BLANK;
    prev_b = ALL_BLANK;

    // Start held high: retriggers every 18 cycles
    value = 16'd4321; is_signed = 1'b0; hex_mode = 1'b0; start = 1'b1;
    pulses = 0; first_p = -1; second_p = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done_a) begin
        pulses++;
        if (first_p < 0) first_p = n;
        else if (second_p < 0) second_p = n;
      end
    end
    start = 1'b0;
    chk("held pulses", 64'(pulses), 64'd2);
    chk("held first", 64'(first_p), 64'd17);
    chk("held period", 64'(second_p - first_p), 64'd18);
    chk("held digits", {8'd0, out_a}, {8'd0, model(16'd4321, 1'b0, 1'b0, 1'b1)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
